gpr_wb_commit: RTL and testbench

Writeback commit arbiter that drives the GPR write side of the operand collector. It merges result streams from `NUM_PORTS` execute units into the single, never-stalling GPR writeback interface. Multi-packet results (sop/eop) stay atomic. On the final packet of each instruction it emits a scoreboard release pulse. It sits between the execute-unit commit outputs and the operand collector's register banks.

---
 rtl/gpr_wb_commit_pkg.sv | 32 +++
 rtl/gpr_wb_commit_if.sv | 49 ++++
 rtl/gpr_wb_rr_arbiter.sv | 36 +++
 rtl/gpr_wb_commit.sv | 127 ++++++++++++
 tb/tb_gpr_wb_commit.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpr_wb_commit_pkg.sv
// rtl/gpr_wb_commit_pkg.sv - shared GPR writeback types, widths and helpers
// Field layout matches the operand collector writeback interface.
package gpr_wb_commit_pkg;

   localparam int GPR_WB_NUM_PORTS     = 4;
   localparam int GPR_WB_NUM_THREADS   = 4;
   localparam int GPR_WB_XLEN          = 32;
   localparam int GPR_WB_NR_BITS       = 6;
   localparam int GPR_WB_WIS_W         = 2;
   localparam int GPR_WB_WIS_BITS      = (GPR_WB_WIS_W > 0) ? GPR_WB_WIS_W : 1;
   localparam int GPR_WB_PERF_CTR_BITS = 44;

   typedef struct packed {
      logic [GPR_WB_WIS_BITS-1:0]                wis;
      logic [GPR_WB_NUM_THREADS-1:0]             tmask;
      logic [GPR_WB_NR_BITS-1:0]                 rd;
      logic                                      wb;
      logic                                      sop;
      logic                                      eop;
      logic [GPR_WB_NUM_THREADS*GPR_WB_XLEN-1:0] data;
   } gpr_wb_req_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } gpr_wb_state_e;

   function automatic int gpr_wb_next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/gpr_wb_commit_if.sv
// rtl/gpr_wb_commit_if.sv - execute-unit commit ports plus GPR write and release outputs
// master drives requests and observes results; slave is the commit arbiter.
interface gpr_wb_commit_if
   import gpr_wb_commit_pkg::*;
#(
   parameter int NUM_PORTS   = GPR_WB_NUM_PORTS,
   parameter int NUM_THREADS = GPR_WB_NUM_THREADS,
   parameter int XLEN        = GPR_WB_XLEN,
   parameter int NR_BITS     = GPR_WB_NR_BITS,
   parameter int WIS_W       = GPR_WB_WIS_W
) ();
   localparam int WIS_BITS = (WIS_W > 0) ? WIS_W : 1;

   logic [NUM_PORTS-1:0]                        in_valid;
   logic [NUM_PORTS-1:0]                        in_ready;
   logic [NUM_PORTS-1:0][WIS_BITS-1:0]          in_wis;
   logic [NUM_PORTS-1:0][NUM_THREADS-1:0]       in_tmask;
   logic [NUM_PORTS-1:0][NR_BITS-1:0]           in_rd;
   logic [NUM_PORTS-1:0]                        in_wb;
   logic [NUM_PORTS-1:0]                        in_sop;
   logic [NUM_PORTS-1:0]                        in_eop;
   logic [NUM_PORTS-1:0][NUM_THREADS*XLEN-1:0]  in_data;

   logic                        wb_valid;
   logic [WIS_BITS-1:0]         wb_wis;
   logic [NUM_THREADS-1:0]      wb_tmask;
   logic [NR_BITS-1:0]          wb_rd;
   logic [NUM_THREADS*XLEN-1:0] wb_data;
   logic                        wb_sop;
   logic                        wb_eop;

   logic                        rel_valid;
   logic [WIS_BITS-1:0]         rel_wis;
   logic [NR_BITS-1:0]          rel_rd;

   modport master (
      output in_valid, in_wis, in_tmask, in_rd, in_wb, in_sop, in_eop, in_data,
      input  in_ready,
      input  wb_valid, wb_wis, wb_tmask, wb_rd, wb_data, wb_sop, wb_eop,
      input  rel_valid, rel_wis, rel_rd
   );

   modport slave (
      input  in_valid, in_wis, in_tmask, in_rd, in_wb, in_sop, in_eop, in_data,
      output in_ready,
      output wb_valid, wb_wis, wb_tmask, wb_rd, wb_data, wb_sop, wb_eop,
      output rel_valid, rel_wis, rel_rd
   );
endinterface

// File: rtl/gpr_wb_rr_arbiter.sv
// rtl/gpr_wb_rr_arbiter.sv - round-robin pick with lock override
// Grant is one-hot or zero; a lock restricts eligibility to lock_idx alone.
module gpr_wb_rr_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_PORTS-1:0] valid,
   input  logic [IDX_W-1:0]     rr_ptr,
   input  logic                 lock_en,
   input  logic [IDX_W-1:0]     lock_idx,
   output logic [NUM_PORTS-1:0] grant,
   output logic [IDX_W-1:0]     win_idx
);
   logic found;
   int   k;

   always_comb begin
      grant   = '0;
      win_idx = '0;
      found   = 1'b0;
      k       = 0;
      if (lock_en) begin
         grant[lock_idx] = valid[lock_idx];
         win_idx         = lock_idx;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            k = (int'(rr_ptr) + i) % NUM_PORTS;
            if (!found && valid[IDX_W'(k)]) begin
               found              = 1'b1;
               grant[IDX_W'(k)]   = 1'b1;
               win_idx            = IDX_W'(k);
            end
         end
      end
   end
endmodule

// File: rtl/gpr_wb_commit.sv
// rtl/gpr_wb_commit.sv - writeback commit arbiter feeding the GPR write port
// Optional stall counter under GPR_WB_PERF_EN.
module gpr_wb_commit
   import gpr_wb_commit_pkg::*;
#(
   parameter int NUM_PORTS     = GPR_WB_NUM_PORTS,
   parameter int NUM_THREADS   = GPR_WB_NUM_THREADS,
   parameter int XLEN          = GPR_WB_XLEN,
   parameter int NR_BITS       = GPR_WB_NR_BITS,
   parameter int WIS_W         = GPR_WB_WIS_W,
   parameter int PERF_CTR_BITS = GPR_WB_PERF_CTR_BITS
) (
   input  logic clk,
   input  logic reset,
   gpr_wb_commit_if.slave bus
`ifdef GPR_WB_PERF_EN
   ,
   output logic [PERF_CTR_BITS-1:0] perf_wb_stalls
`endif
);
   localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int WIS_BITS = (WIS_W > 0) ? WIS_W : 1;

   gpr_wb_state_e               state;
   logic [IDX_W-1:0]            owner;
   logic [IDX_W-1:0]            rr_ptr;
   logic [IDX_W-1:0]            win_idx;
   logic [NUM_PORTS-1:0]        grant;
   logic                        fire;
   logic [WIS_BITS-1:0]         s_wis;
   logic [NUM_THREADS-1:0]      s_tmask;
   logic [NR_BITS-1:0]          s_rd;
   logic                        s_wb;
   logic                        s_sop;
   logic                        s_eop;
   logic [NUM_THREADS*XLEN-1:0] s_data;
   logic                        s_write;
   logic                        s_release;

   gpr_wb_rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_arb (
      .valid    (bus.in_valid),
      .rr_ptr   (rr_ptr),
      .lock_en  (state == ST_LOCKED),
      .lock_idx (owner),
      .grant    (grant),
      .win_idx  (win_idx)
   );

   assign bus.in_ready = grant;
   assign fire         = |grant;

   assign s_wis   = (WIS_W > 0) ? bus.in_wis[win_idx] : '0;
   assign s_tmask = bus.in_tmask[win_idx];
   assign s_rd    = bus.in_rd[win_idx];
   assign s_wb    = bus.in_wb[win_idx];
   assign s_sop   = bus.in_sop[win_idx];
   assign s_eop   = bus.in_eop[win_idx];
   assign s_data  = bus.in_data[win_idx];

   // r0 is hardwired; an empty lane mask still releases the scoreboard entry
   assign s_write   = fire && s_wb && (s_rd != '0) && (|s_tmask);
   assign s_release = fire && s_eop && s_wb && (s_rd != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         owner         <= '0;
         rr_ptr        <= '0;
         bus.wb_valid  <= 1'b0;
         bus.wb_wis    <= '0;
         bus.wb_tmask  <= '0;
         bus.wb_rd     <= '0;
         bus.wb_data   <= '0;
         bus.wb_sop    <= 1'b0;
         bus.wb_eop    <= 1'b0;
         bus.rel_valid <= 1'b0;
         bus.rel_wis   <= '0;
         bus.rel_rd    <= '0;
      end else begin
         bus.wb_valid  <= s_write;
         bus.rel_valid <= s_release;
         if (fire) begin
            bus.wb_wis   <= s_wis;
            bus.wb_tmask <= s_tmask;
            bus.wb_rd    <= s_rd;
            bus.wb_data  <= s_data;
            bus.wb_sop   <= s_sop;
            bus.wb_eop   <= s_eop;
            bus.rel_wis  <= s_wis;
            bus.rel_rd   <= s_rd;
         end
         case (state)
            ST_IDLE: begin
               if (fire) begin
                  if (s_eop) begin
                     rr_ptr <= IDX_W'(gpr_wb_next_idx(int'(win_idx), NUM_PORTS));
                  end else begin
                     state <= ST_LOCKED;
                     owner <= win_idx;
                  end
               end
            end
            ST_LOCKED: begin
               if (fire && s_eop) begin
                  state  <= ST_IDLE;
                  rr_ptr <= IDX_W'(gpr_wb_next_idx(int'(owner), NUM_PORTS));
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef GPR_WB_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_wb_stalls <= '0;
      end else if ((|(bus.in_valid & ~grant)) && !(&perf_wb_stalls)) begin
         perf_wb_stalls <= perf_wb_stalls + PERF_CTR_BITS'(1);
      end
   end
`endif

endmodule

// File: tb/tb_gpr_wb_commit.sv
// tb/tb_gpr_wb_commit.sv - self-checking bench for gpr_wb_commit
// Directed scenarios with literal expectations, then randomized traffic against a behavioural model.
module tb_gpr_wb_commit;
   import gpr_wb_commit_pkg::*;

   localparam int NP = GPR_WB_NUM_PORTS;
   localparam int DW = GPR_WB_NUM_THREADS * GPR_WB_XLEN;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   gpr_wb_commit_if bus ();

`ifdef GPR_WB_PERF_EN
   logic [GPR_WB_PERF_CTR_BITS-1:0] perf_wb_stalls;
`endif

   gpr_wb_commit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef GPR_WB_PERF_EN
      ,
      .perf_wb_stalls (perf_wb_stalls)
`endif
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Behavioural model state
   bit                              m_locked = 1'b0;
   int                              m_owner = 0;
   int                              m_ptr = 0;
   logic [GPR_WB_PERF_CTR_BITS-1:0] m_perf = '0;
   bit                              started = 1'b0;
   bit                              e_wb_valid = 1'b0;
   bit                              e_rel_valid = 1'b0;
   bit                              e_all_zero = 1'b0;
   gpr_wb_req_t                     e_req;

   function automatic logic [NP-1:0] model_grant(input logic [NP-1:0] v);
      logic [NP-1:0] g = '0;
      if (m_locked) begin
         if (v[m_owner]) g[m_owner] = 1'b1;
      end else begin
         for (int i = 0; i < NP; i++) begin
            int p = (m_ptr + i) % NP;
            if (v[p]) begin
               g[p] = 1'b1;
               break;
            end
         end
      end
      return g;
   endfunction

   initial begin
      logic [NP-1:0] g;
      e_req = '0;
      forever begin
         @(negedge clk);
         if (started) begin
            check("wb_valid", DW'(bus.wb_valid), DW'(e_wb_valid));
            check("rel_valid", DW'(bus.rel_valid), DW'(e_rel_valid));
            if (e_wb_valid) begin
               check("wb_rd", DW'(bus.wb_rd), DW'(e_req.rd));
               check("wb_wis", DW'(bus.wb_wis), DW'(e_req.wis));
               check("wb_tmask", DW'(bus.wb_tmask), DW'(e_req.tmask));
               check("wb_data", bus.wb_data, e_req.data);
               check("wb_sop", DW'(bus.wb_sop), DW'(e_req.sop));
               check("wb_eop", DW'(bus.wb_eop), DW'(e_req.eop));
            end
            if (e_rel_valid) begin
               check("rel_rd", DW'(bus.rel_rd), DW'(e_req.rd));
               check("rel_wis", DW'(bus.rel_wis), DW'(e_req.wis));
            end
            if (e_all_zero) begin
               check("rst_wb_rd", DW'(bus.wb_rd), '0);
               check("rst_wb_wis", DW'(bus.wb_wis), '0);
               check("rst_wb_tmask", DW'(bus.wb_tmask), '0);
               check("rst_wb_data", bus.wb_data, '0);
               check("rst_wb_flags", DW'({bus.wb_sop, bus.wb_eop}), '0);
               check("rst_rel", DW'({bus.rel_wis, bus.rel_rd}), '0);
            end
`ifdef GPR_WB_PERF_EN
            check("perf_wb_stalls", DW'(perf_wb_stalls), DW'(m_perf));
`endif
            g = model_grant(bus.in_valid);
            check("in_ready", DW'(bus.in_ready), DW'(g));
         end else begin
            g = '0;
         end
         if (reset) begin
            started     = 1'b1;
            m_locked    = 1'b0;
            m_owner     = 0;
            m_ptr       = 0;
            m_perf      = '0;
            e_wb_valid  = 1'b0;
            e_rel_valid = 1'b0;
            e_all_zero  = 1'b1;
         end else if (started) begin
            e_all_zero  = 1'b0;
            e_wb_valid  = 1'b0;
            e_rel_valid = 1'b0;
            if ((|(bus.in_valid & ~g)) && (m_perf != '1)) m_perf = m_perf + 1;
            for (int p = 0; p < NP; p++) begin
               if (g[p]) begin
                  e_req.wis   = bus.in_wis[p];
                  e_req.tmask = bus.in_tmask[p];
                  e_req.rd    = bus.in_rd[p];
                  e_req.wb    = bus.in_wb[p];
                  e_req.sop   = bus.in_sop[p];
                  e_req.eop   = bus.in_eop[p];
                  e_req.data  = bus.in_data[p];
                  e_wb_valid  = e_req.wb && (e_req.rd != 0) && (e_req.tmask != 0);
                  e_rel_valid = e_req.eop && e_req.wb && (e_req.rd != 0);
                  if (e_req.eop) begin
                     m_locked = 1'b0;
                     m_ptr    = (p + 1) % NP;
                  end else begin
                     m_locked = 1'b1;
                     m_owner  = p;
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.in_valid = '0;
      bus.in_wis   = '0;
      bus.in_tmask = '0;
      bus.in_rd    = '0;
      bus.in_wb    = '0;
      bus.in_sop   = '0;
      bus.in_eop   = '0;
      bus.in_data  = '0;
   endtask

   task automatic set_pkt(input int p, input logic [GPR_WB_WIS_BITS-1:0] wis,
                          input logic [GPR_WB_NUM_THREADS-1:0] tmask,
                          input logic [GPR_WB_NR_BITS-1:0] rd, input logic wb,
                          input logic sop, input logic eop, input logic [DW-1:0] data);
      bus.in_valid[p] = 1'b1;
      bus.in_wis[p]   = wis;
      bus.in_tmask[p] = tmask;
      bus.in_rd[p]    = rd;
      bus.in_wb[p]    = wb;
      bus.in_sop[p]   = sop;
      bus.in_eop[p]   = eop;
      bus.in_data[p]  = data;
   endtask

   task automatic do_reset();
      step();
      clear_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [NP-1:0] rr_exp [6];
      logic [GPR_WB_NR_BITS-1:0] c_rd [3];
      logic c_wb [3];
      logic [GPR_WB_NUM_THREADS-1:0] c_tm [3];
      logic c_rel [3];
      rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
      c_rd   = '{6'd0, 6'd3, 6'd3};
      c_wb   = '{1'b1, 1'b0, 1'b1};
      c_tm   = '{4'hF, 4'hF, 4'h0};
      c_rel  = '{1'b0, 1'b0, 1'b1};

      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Single packet on port 2
      set_pkt(2, 2'd1, 4'b1011, 6'd5, 1'b1, 1'b1, 1'b1, 128'hA);
      @(negedge clk);
      check("t1_ready", DW'(bus.in_ready), DW'(4'b0100));
      step();
      clear_inputs();
      @(negedge clk);
      check("t1_wb_valid", DW'(bus.wb_valid), DW'(1'b1));
      check("t1_wb_rd", DW'(bus.wb_rd), DW'(6'd5));
      check("t1_wb_tmask", DW'(bus.wb_tmask), DW'(4'b1011));
      check("t1_wb_data", bus.wb_data, 128'hA);
      check("t1_rel_valid", DW'(bus.rel_valid), DW'(1'b1));
      check("t1_rel_rd", DW'(bus.rel_rd), DW'(6'd5));

      // Round robin over ports 0, 1, 3
      do_reset();
      set_pkt(0, 2'd0, 4'hF, 6'd1, 1'b1, 1'b1, 1'b1, rand_data());
      set_pkt(1, 2'd1, 4'hF, 6'd2, 1'b1, 1'b1, 1'b1, rand_data());
      set_pkt(3, 2'd3, 4'hF, 6'd3, 1'b1, 1'b1, 1'b1, rand_data());
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("t2_grant%0d", c), DW'(bus.in_ready), DW'(rr_exp[c]));
         step();
      end

      // Three-packet instruction on port 1 locks out port 0
      do_reset();
      set_pkt(0, 2'd0, 4'hF, 6'd9, 1'b1, 1'b1, 1'b1, rand_data());
      @(negedge clk);
      check("t3_g0", DW'(bus.in_ready), DW'(4'b0001));
      step();
      set_pkt(1, 2'd2, 4'hF, 6'd7, 1'b1, 1'b1, 1'b0, rand_data());
      @(negedge clk);
      check("t3_g1", DW'(bus.in_ready), DW'(4'b0010));
      step();
      set_pkt(1, 2'd2, 4'hF, 6'd7, 1'b1, 1'b0, 1'b0, rand_data());
      @(negedge clk);
      check("t3_g2", DW'(bus.in_ready), DW'(4'b0010));
      check("t3_w1_rel", DW'({bus.wb_valid, bus.rel_valid}), DW'(2'b10));
      check("t3_w1_rd", DW'(bus.wb_rd), DW'(6'd7));
      step();
      set_pkt(1, 2'd2, 4'hF, 6'd7, 1'b1, 1'b0, 1'b1, rand_data());
      @(negedge clk);
      check("t3_g3", DW'(bus.in_ready), DW'(4'b0010));
      check("t3_w2_rel", DW'({bus.wb_valid, bus.rel_valid}), DW'(2'b10));
      step();
      bus.in_valid[1] = 1'b0;
      @(negedge clk);
      check("t3_g4", DW'(bus.in_ready), DW'(4'b0001));
      check("t3_w3_rel", DW'({bus.wb_valid, bus.rel_valid}), DW'(2'b11));
      check("t3_rel_rd", DW'(bus.rel_rd), DW'(6'd7));
      step();
      clear_inputs();
      @(negedge clk);
      check("t3_p0_rel_rd", DW'(bus.rel_rd), DW'(6'd9));

      // Non-writing packets
      for (int c = 0; c < 3; c++) begin
         step();
         clear_inputs();
         set_pkt(3, 2'd1, c_tm[c], c_rd[c], c_wb[c], 1'b1, 1'b1, rand_data());
         @(negedge clk);
         check($sformatf("t4_ready%0d", c), DW'(bus.in_ready), DW'(4'b1000));
         step();
         clear_inputs();
         @(negedge clk);
         check($sformatf("t4_wb%0d", c), DW'(bus.wb_valid), DW'(1'b0));
         check($sformatf("t4_rel%0d", c), DW'(bus.rel_valid), DW'(c_rel[c]));
      end

      // Reset while locked on port 2
      do_reset();
      set_pkt(2, 2'd2, 4'hF, 6'd4, 1'b1, 1'b1, 1'b0, rand_data());
      @(negedge clk);
      check("t5_lock", DW'(bus.in_ready), DW'(4'b0100));
      step();
      reset = 1'b1;
      set_pkt(0, 2'd0, 4'hF, 6'd8, 1'b1, 1'b1, 1'b1, rand_data());
      set_pkt(2, 2'd2, 4'hF, 6'd4, 1'b1, 1'b0, 1'b1, rand_data());
      step();
      reset = 1'b0;
      @(negedge clk);
      check("t5_wb_valid", DW'(bus.wb_valid), '0);
      check("t5_rel_valid", DW'(bus.rel_valid), '0);
      check("t5_wb_rd", DW'(bus.wb_rd), '0);
      check("t5_wb_data", bus.wb_data, '0);
      check("t5_ready", DW'(bus.in_ready), DW'(4'b0001));

`ifdef GPR_WB_PERF_EN
      do_reset();
      for (int p = 0; p < NP; p++) set_pkt(p, 2'd0, 4'hF, 6'd1, 1'b1, 1'b1, 1'b1, rand_data());
      repeat (10) step();
      clear_inputs();
      @(negedge clk);
      check("t6_perf", DW'(perf_wb_stalls), DW'(10));
`endif

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 255) == 0);
         for (int p = 0; p < NP; p++) begin
            bus.in_valid[p] = ($urandom_range(0, 9) < 7);
            bus.in_wis[p]   = GPR_WB_WIS_BITS'($urandom);
            bus.in_tmask[p] = GPR_WB_NUM_THREADS'($urandom);
            bus.in_rd[p]    = GPR_WB_NR_BITS'($urandom_range(0, 15));
            bus.in_wb[p]    = ($urandom_range(0, 4) != 0);
            bus.in_sop[p]   = $urandom_range(0, 1);
            bus.in_eop[p]   = $urandom_range(0, 1);
            bus.in_data[p]  = rand_data();
         end
         step();
      end
      reset = 1'b0;
      clear_inputs();
      step();
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
